uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 29 ++
 rtl/rx_sync.sv | 26 ++
 rtl/uart_receiver.sv | 179 +++++++++++++++++
 tb/tb_uart_receiver.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and the frame
// bit positions used by both the transmitter and the receiver.
// Configuration macro: UART_RX_PARITY_EN (parity bit present in the frame).
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;

  // Frame layout, counted in bit periods from the start bit.
  localparam int unsigned START_POS  = 0;
  localparam int unsigned DATA_POS   = 1;
  localparam int unsigned PARITY_POS = DATA_POS + DATA_BITS;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned STOP_POS   = PARITY_POS + 1;
`else
  localparam int unsigned STOP_POS   = PARITY_POS;
`endif
  localparam int unsigned FRAME_BITS = STOP_POS + 1;

  // Explicit encodings keep state values identical to the legacy design.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_e;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Ports: clk, rst_n (async active-low, flops reset to 1 = idle line),
//        d (asynchronous input), q (synchronized output).
module rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start, 8 data bits LSB first, optional parity,
// stop. Each bit is sampled once near mid-bit on the synchronized line.
// Configuration macro: UART_RX_PARITY_EN (when undefined the frame is 10 bits
// and parityError is tied low).
// Ports:
//   uart_clock  - clock at OVERSAMPLE x baud
//   rst_n       - asynchronous active-low reset
//   rx          - serial line, idle high, asynchronous
//   data        - last accepted byte, held between frames
//   dataValid   - one-cycle pulse when data updates
//   parityError - one-cycle pulse with dataValid on parity mismatch
//   frameError  - one-cycle pulse when the stop bit samples low
//   busy        - high from start detection until back in IDLE
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       uart_clock,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       dataValid,
  output logic       parityError,
  output logic       frameError,
  output logic       busy
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] TICK_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  logic rx_s;
  logic rx_prev_q;

  uart_state_e            state_q, state_d;
  logic [CW-1:0]          tick_q, tick_d;
  logic [2:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   par_err_q, par_err_d;
`endif

  rx_sync u_rx_sync (
    .clk   (uart_clock),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    par_err_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // rx_prev_q tracks the line every cycle, so an edge landing on the
        // first IDLE cycle after STOP is still caught.
        if (rx_prev_q && !rx_s) begin
          state_d = ST_START;
          tick_d  = '0;
        end
      end
      ST_START: begin
        if (tick_q == TICK_HALF) begin
          tick_d = '0;
          bit_d  = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_q == TICK_LAST) begin
          tick_d    = '0;
          par_bad_d = rx_s ^ (^shift_q) ^ PARITY_ODD;
          state_d   = ST_STOP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (rx_s) begin
            data_d    = shift_q;
            valid_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
            par_err_d = par_bad_q;
`endif
            state_d   = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_IDLE;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge uart_clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      rx_prev_q   <= rx_s;
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign data       = data_q;
  assign dataValid  = valid_q;
  assign frameError = frame_err_q;
  assign busy       = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parityError = par_err_q;
`else
  assign parityError = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver (OVERSAMPLE=16, even parity).
// Frames are pushed to a scoreboard queue as they are driven; a monitor on
// the falling clock edge pops and compares whenever an output pulse appears.
module tb_uart_receiver;

  localparam int unsigned OS      = 16;
  localparam bit          PAR_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit          PAR_EN  = 1'b1;
`else
  localparam bit          PAR_EN  = 1'b0;
`endif

  logic       uart_clock = 1'b0;
  logic       rst_n      = 1'b0;
  logic       rx         = 1'b1;
  logic [7:0] data;
  logic       dataValid;
  logic       parityError;
  logic       frameError;
  logic       busy;

  typedef struct packed {
    logic       is_frame;
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_data = 8'h00;
  int         n_checks  = 0;
  int         n_errors  = 0;

  uart_receiver #(
    .OVERSAMPLE (OS),
    .PARITY_ODD (PAR_ODD)
  ) dut (
    .uart_clock  (uart_clock),
    .rst_n       (rst_n),
    .rx          (rx),
    .data        (data),
    .dataValid   (dataValid),
    .parityError (parityError),
    .frameError  (frameError),
    .busy        (busy)
  );

  always #5 uart_clock = ~uart_clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic bit_hold(input logic v);
    rx = v;
    repeat (OS) @(negedge uart_clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    exp_t e;
    if (s) begin
      e.is_frame = 1'b0;
      e.data     = d;
      e.perr     = PAR_EN && (p != ((^d) ^ PAR_ODD));
      last_data  = d;
    end else begin
      e.is_frame = 1'b1;
      e.data     = last_data;
      e.perr     = 1'b0;
    end
    sb.push_back(e);
    bit_hold(1'b0);
    for (int i = 0; i < uart_pkg::DATA_BITS; i++) bit_hold(d[i]);
    if (PAR_EN) bit_hold(p);
    bit_hold(s);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge uart_clock);
    check_eq({"drain_", tag}, 32'(sb.size()), 0);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge uart_clock) begin
    exp_t e;
    if (dataValid) begin
      if (sb.size() == 0) check_eq("unexpected_valid", 32'(dataValid), 0);
      else begin
        e = sb.pop_front();
        check_eq("valid_kind", 32'(e.is_frame), 32'(1'b0));
        check_eq("valid_data", 32'(data), 32'(e.data));
        check_eq("valid_perr", 32'(parityError), 32'(e.perr));
        check_eq("valid_no_ferr", 32'(frameError), 0);
        check_eq("valid_busy_low", 32'(busy), 0);
      end
    end else if (frameError) begin
      if (sb.size() == 0) check_eq("unexpected_ferr", 32'(frameError), 0);
      else begin
        e = sb.pop_front();
        check_eq("ferr_kind", 32'(e.is_frame), 32'(1'b1));
        check_eq("ferr_data_held", 32'(data), 32'(e.data));
        check_eq("ferr_no_perr", 32'(parityError), 0);
        check_eq("ferr_busy", 32'(busy), 1);
      end
    end
    if (parityError && !dataValid) check_eq("perr_without_valid", 32'(parityError), 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] tbl_d [3];
    logic       tbl_p [3];
    tbl_d[0] = 8'h80; tbl_p[0] = 1'b1;  // correct parity
    tbl_d[1] = 8'h7F; tbl_p[1] = 1'b0;  // wrong parity
    tbl_d[2] = 8'hFF; tbl_p[2] = 1'b0;  // correct parity

    // Reset state
    repeat (3) @(negedge uart_clock);
    check_eq("rst_data", 32'(data), 0);
    check_eq("rst_valid", 32'(dataValid), 0);
    check_eq("rst_perr", 32'(parityError), 0);
    check_eq("rst_ferr", 32'(frameError), 0);
    check_eq("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge uart_clock);

    // Good frame, then wrong parity
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_drain("a5");
    check_eq("a5_busy_idle", 32'(busy), 0);
    send_frame(8'h01, 1'b0, 1'b1);
    wait_drain("01");

    // Start-bit glitch: busy must fall within 9 cycles of the synchronized edge
    repeat (5) @(negedge uart_clock);
    rx = 1'b0;
    repeat (4) @(negedge uart_clock);
    rx = 1'b1;
    for (int i = 0; i < 4 && !busy; i++) @(negedge uart_clock);
    check_eq("glitch_busy_rise", 32'(busy), 1);
    for (int i = 0; i < 9 && busy; i++) @(negedge uart_clock);
    check_eq("glitch_busy_fall", 32'(busy), 0);
    repeat (20) @(negedge uart_clock);

    // Stop bit low: frame error, hold in WAIT_IDLE until the line goes high
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (20) @(negedge uart_clock);
    check_eq("ferr_wait_busy", 32'(busy), 1);
    wait_drain("3c");
    rx = 1'b1;
    for (int i = 0; i < 6 && busy; i++) @(negedge uart_clock);
    check_eq("ferr_release_busy", 32'(busy), 0);
    check_eq("ferr_data_kept", 32'(data), 32'(8'h01));
    repeat (10) @(negedge uart_clock);

    // Back-to-back frames with no idle gap
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    wait_drain("b2b");
    repeat (10) @(negedge uart_clock);

    // Parity table
    for (int k = 0; k < 3; k++) begin
      send_frame(tbl_d[k], tbl_p[k], 1'b1);
      wait_drain("tbl");
      repeat (5) @(negedge uart_clock);
    end

    // Reset during data bit 4 of 0xFF
    bit_hold(1'b0);
    for (int i = 0; i < 4; i++) bit_hold(1'b1);
    rx = 1'b1;
    repeat (OS / 2) @(negedge uart_clock);
    rst_n = 1'b0;
    repeat (3) @(negedge uart_clock);
    check_eq("midrst_busy", 32'(busy), 0);
    check_eq("midrst_data", 32'(data), 0);
    last_data = 8'h00;
    rst_n = 1'b1;
    repeat (OS * 8) @(negedge uart_clock);
    check_eq("midrst_idle", 32'(busy), 0);
    send_frame(8'h12, 1'b0, 1'b1);
    wait_drain("12");
    check_eq("final_data", 32'(data), 32'(8'h12));

    repeat (5) @(negedge uart_clock);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
